// File: rtl/run_det_pkg.sv
// Shared state encoding for the run-length pattern detector.
package run_det_pkg;
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] IDLE   = 2'b00;
    localparam logic [ST_W-1:0] COUNT  = 2'b01;
    localparam logic [ST_W-1:0] ARMED  = 2'b10;
    localparam logic [ST_W-1:0] REJECT = 2'b11;
endpackage

// File: rtl/run_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/run_pattern_detector.sv
// Detects a run of >= min_run ones terminated by a zero.
// Define RUN_DET_MAXLEN_EN to add max_run and the overlong pulse.
module run_pattern_detector
    import run_det_pkg::*;
#(
    parameter int RW = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            level,
    input  logic            en,
    input  logic            clr,
    input  logic [RW-1:0]   min_run,
`ifdef RUN_DET_MAXLEN_EN
    input  logic [RW-1:0]   max_run,
    output logic            overlong,
`endif
    output logic            match,
    output logic [RW-1:0]   run_len,
    output logic [CW-1:0]   match_count,
    output logic [ST_W-1:0] state
);
    logic [ST_W-1:0] state_q, state_d;
    logic            match_q, match_d;
    logic [RW-1:0]   run_len_q, run_len_d;
    logic [RW-1:0]   run_cnt_q;
    logic [RW-1:0]   min_eff;
    logic [RW:0]     cnt_nxt;
    logic            cnt_inc, cnt_clr, mc_inc;
`ifdef RUN_DET_MAXLEN_EN
    logic            ov_q, ov_d;
`endif

    sat_counter #(.W(RW)) u_run_cnt (
        .clk (clk),
        .rst (reset),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .q   (run_cnt_q)
    );

    sat_counter #(.W(CW)) u_match_cnt (
        .clk (clk),
        .rst (reset),
        .clr (clr),
        .inc (mc_inc),
        .q   (match_count)
    );

    always_comb begin
        min_eff   = (min_run == '0) ? RW'(1) : min_run;
        cnt_nxt   = {1'b0, run_cnt_q} + (RW+1)'(1);
        state_d   = state_q;
        match_d   = 1'b0;
        run_len_d = run_len_q;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        mc_inc    = 1'b0;
`ifdef RUN_DET_MAXLEN_EN
        ov_d      = 1'b0;
`endif
        if (clr) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (level) begin
                        cnt_inc = 1'b1;
                        state_d = (min_eff == RW'(1)) ? ARMED : COUNT;
                    end
                end
                COUNT: begin
                    if (level) begin
                        cnt_inc = 1'b1;
                        if (cnt_nxt >= {1'b0, min_eff}) state_d = ARMED;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (level) begin
`ifdef RUN_DET_MAXLEN_EN
                        if (max_run != '0 && cnt_nxt > {1'b0, max_run})
                            state_d = REJECT;
                        else
                            cnt_inc = 1'b1;
`else
                        cnt_inc = 1'b1;
`endif
                    end else begin
                        cnt_clr   = 1'b1;
                        state_d   = IDLE;
                        match_d   = 1'b1;
                        run_len_d = run_cnt_q;
                        mc_inc    = 1'b1;
                    end
                end
`ifdef RUN_DET_MAXLEN_EN
                REJECT: begin
                    if (!level) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                        ov_d    = 1'b1;
                    end
                end
`endif
                default: begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            match_q   <= 1'b0;
            run_len_q <= '0;
`ifdef RUN_DET_MAXLEN_EN
            ov_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            run_len_q <= run_len_d;
`ifdef RUN_DET_MAXLEN_EN
            ov_q      <= ov_d;
`endif
        end
    end

    assign state   = state_q;
    assign match   = match_q;
    assign run_len = run_len_q;
`ifdef RUN_DET_MAXLEN_EN
    assign overlong = ov_q;
`endif
endmodule

// File: tb/tb_run_pattern_detector.sv
// Scoreboard bench for run_pattern_detector against a run-length reference model.
module tb_run_pattern_detector;
    localparam int RW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          level = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [RW-1:0] min_run = '0;
    logic          match;
    logic [RW-1:0] run_len;
    logic [CW-1:0] match_count;
    logic [1:0]    state;
    logic          act_ov;
`ifdef RUN_DET_MAXLEN_EN
    logic [RW-1:0] max_run = '0;
    logic          overlong;
    assign act_ov = overlong;
`else
    assign act_ov = 1'b0;
`endif

    run_pattern_detector #(.RW(RW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .en          (en),
        .clr         (clr),
        .min_run     (min_run),
`ifdef RUN_DET_MAXLEN_EN
        .max_run     (max_run),
        .overlong    (overlong),
`endif
        .match       (match),
        .run_len     (run_len),
        .match_count (match_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          m;
        logic [RW-1:0] rl;
        logic [CW-1:0] mc;
        logic [1:0]    st;
        logic          ov;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model: length of the current run of ones and its status
    int L = 0;
    bit armed = 0;
    bit rej = 0;
    int mcount = 0;
    int rlen = 0;
    int next_min = 3;
    int next_max = 0;

    task automatic step(input logic lv, input logic e, input logic c);
        exp_t x;
        int meff;
        @(negedge clk);
        level = lv;
        en = e;
        clr = c;
        min_run = RW'(next_min);
`ifdef RUN_DET_MAXLEN_EN
        max_run = RW'(next_max);
`endif
        meff = (next_min == 0) ? 1 : next_min;
        x.m = 0;
        x.ov = 0;
        if (c) begin
            L = 0; armed = 0; rej = 0; mcount = 0;
        end else if (e) begin
            if (lv) begin
                if (rej) begin
                end else if (armed && next_max != 0 && L + 1 > next_max) begin
                    rej = 1;
                end else begin
                    L++;
                    if (L >= meff) armed = 1;
                end
            end else begin
                if (rej) x.ov = 1;
                else if (armed) begin
                    x.m = 1;
                    rlen = (L > (1 << RW) - 1) ? (1 << RW) - 1 : L;
                    if (mcount < (1 << CW) - 1) mcount++;
                end
                L = 0; armed = 0; rej = 0;
            end
        end
        x.rl = RW'(rlen);
        x.mc = CW'(mcount);
        x.st = rej ? 2'd3 : (L == 0) ? 2'd0 : armed ? 2'd2 : 2'd1;
        q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (match !== 1'b0 || run_len !== '0 || match_count !== '0 || state !== 2'd0 || act_ov !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got m=%0b rl=%0d mc=%0d st=%0d want all 0",
                     match, run_len, match_count, state);
        end
        L = 0; armed = 0; rej = 0; mcount = 0; rlen = 0;
        x.m = 0; x.rl = '0; x.mc = '0; x.st = 2'd0; x.ov = 0;
        q.push_back(x);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (match !== x.m || run_len !== x.rl || match_count !== x.mc ||
                state !== x.st || act_ov !== x.ov) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got m=%0b rl=%0d mc=%0d st=%0d ov=%0b want m=%0b rl=%0d mc=%0d st=%0d ov=%0b",
                         $time, match, run_len, match_count, state, act_ov,
                         x.m, x.rl, x.mc, x.st, x.ov);
            end
        end
    end

    initial begin
        do_reset();

        next_min = 3;
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
        settle();
        chk("basic_match", match, 1);
        chk("basic_run_len", run_len, 3);
        chk("basic_count", match_count, 1);

        step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
        settle();
        chk("short_run_no_match", match, 0);
        chk("short_run_count", match_count, 1);
        run(5);
        settle();
        chk("run5_len", run_len, 5);

        run(20);
        settle();
        chk("saturated_len", run_len, 15);
        chk("saturated_count", match_count, 3);

        next_min = 0;
        step(0, 1, 1);
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
        settle();
        chk("min0_count", match_count, 2);
        chk("min0_len", run_len, 1);
        for (int i = 0; i < 298; i++) begin
            step(1, 1, 0);
            step(0, 1, 0);
        end
        settle();
        chk("count_saturates", match_count, 255);

        next_min = 3;
        step(1, 1, 1);
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 1);
        run(3);
        settle();
        chk("clr_count", match_count, 1);
        chk("clr_len", run_len, 3);

        step(1, 1, 0); step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        settle();
        chk("en0_state_frozen", state, 1);
        chk("en0_no_match", match, 0);
        step(1, 1, 0); step(0, 1, 0);
        settle();
        chk("en0_resume_len", run_len, 3);

        step(1, 1, 0); step(1, 1, 0);
        do_reset();

`ifdef RUN_DET_MAXLEN_EN
        next_min = 3;
        next_max = 5;
        run(6);
        settle();
        chk("overlong_pulse", overlong, 1);
        chk("overlong_no_match", match, 0);
        chk("overlong_count", match_count, 0);
        run(5);
        settle();
        chk("max_exact_match", match, 1);
        chk("max_exact_len", run_len, 5);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) next_min = $urandom_range(0, 15);
`ifdef RUN_DET_MAXLEN_EN
            if ($urandom_range(0, 49) == 0) next_max = $urandom_range(0, 15);
`endif
            step(logic'($urandom_range(0, 99) < 75),
                 logic'($urandom_range(0, 99) < 90),
                 logic'($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_pattern_detector.md
Name: run_pattern_detector

Overview:
Parametrised successor to the fixed "three-ones-then-zero" detector. Samples a serial level input once per clock and detects a run of at least min_run consecutive 1s terminated by a 0. Outputs a one-cycle registered match pulse, the captured run length and a saturating match count. Feeds the downstream counter/display path in place of the fixed-pattern FSM.

Parameters:
RW, 4, width of the run-length counter, min_run and run_len; runs saturate at 2^RW-1
CW, 8, width of the saturating match counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
level  in  1  serial input, sampled on each rising clk edge while en=1
en  in  1  sample enable; 0 freezes all state and forces match=0
clr  in  1  synchronous clear of match_count and FSM; priority over en
min_run  in  RW  required minimum run of 1s; 0 is treated as 1
match  out  1  registered one-cycle pulse on a detected pattern
run_len  out  RW  length of the last matched run, held until the next match
match_count  out  CW  saturating count of matches
state  out  2  current FSM state, for test

Behaviour:
- Reset: state=IDLE, run_cnt=0, match=0, run_len=0, match_count=0. Reset mid-run discards the partial run.
- Effective minimum: min_eff = (min_run==0) ? 1 : min_run. Evaluated every cycle.
- States: IDLE=00, COUNT=01, ARMED=10; 11 is unused (REJECT with the optional feature).
- IDLE: level=1 -> run_cnt=1, go to ARMED if min_eff==1, else COUNT. level=0 -> stay.
- COUNT: level=1 -> run_cnt+1, go to ARMED if run_cnt+1 >= min_eff. level=0 -> IDLE with no match, run_cnt=0.
- ARMED: level=1 -> stay, run_cnt increments and saturates at 2^RW-1. level=0 -> IDLE, match=1, run_len=run_cnt, match_count +1 saturating at 2^CW-1, run_cnt=0.
- Once in ARMED, the block stays armed even if min_run is raised mid-run.
- Latency: match, run_len and match_count update on the same edge that samples the terminating 0. match is high for exactly that one cycle.
- A 0 terminates at most one match. A 1 immediately after a match starts a new run from IDLE next cycle.
- en=0: no state, counter or run_len change; match=0.
- clr=1: next edge sets state=IDLE, run_cnt=0, match=0, match_count=0; run_len keeps its value.
- Illegal state 11 (macro absent) -> IDLE next edge, no match.
- All outputs are driven directly from registers.

Optional Feature:
RUN_DET_MAXLEN_EN
- Defined: adds input max_run [RW-1:0] and output overlong (1 bit, registered pulse). max_run=0 means no upper limit.
- In ARMED with level=1, if max_run!=0 and run_cnt+1 > max_run, the FSM goes to REJECT (11).
- REJECT: level=1 -> stay, no counting. level=0 -> IDLE with overlong=1 for one cycle; match stays 0 and match_count is unchanged.
- overlong resets to 0 and is cleared by clr.
- Undefined: no max_run or overlong ports, and any-length run of at least min_eff matches.

Decomposition:
- Shared package run_det_pkg: state localparams IDLE/COUNT/ARMED/REJECT and the 2-bit state width constant.
- One sub-module sat_counter: parametrised width, inc and clr inputs, saturates at all-ones. Instantiated for run_cnt and match_count.

Test Plan:
- min_run=3, level 1,1,1,0 -> match pulse on the 4th edge, run_len=3, match_count=1, state sequence 01,01,10,00.
- min_run=3, level 1,1,0 -> no match, match_count=0; then 1,1,1,1,1,0 -> match, run_len=5.
- RW=4, min_run=3, 20 ones then 0 -> run_len=15 (saturated), one match.
- min_run=0, level 1,0,1,0 -> two matches, run_len=1 each, match_count=2; CW=8 with 300 matches -> match_count=255.
- clr asserted after 2 ones, then 1,1,1,0 -> match_count=1, run_len=3. en=0 for 5 cycles mid-run -> run_cnt frozen and match held at 0. reset asserted mid-run -> all outputs 0 immediately.
- With RUN_DET_MAXLEN_EN, min_run=3, max_run=5: 6 ones then 0 -> overlong=1, match=0, count unchanged; 5 ones then 0 -> match=1, run_len=5.
